// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the multi-channel performance monitor:
//   - perf_mode_e : counter overflow behaviour (wrap or saturate)
//   - default width constants used as parameter defaults
//   - perf_sel_width(): width of the read-select port (event shadows + cycle)
// -----------------------------------------------------------------------------
package perf_pkg;

  typedef enum logic {
    PERF_WRAP = 1'b0,
    PERF_SAT  = 1'b1
  } perf_mode_e;

  localparam int unsigned PERF_DEF_NUM_EVENTS    = 4;
  localparam int unsigned PERF_DEF_COUNTER_WIDTH = 32;
  localparam int unsigned PERF_DEF_INC_WIDTH     = 1;

  // One select code per event shadow plus one for the cycle shadow.
  function automatic int unsigned perf_sel_width(input int unsigned num_events);
    return $clog2(num_events + 1);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// -----------------------------------------------------------------------------
// perf_counter_cell
// One live counter with a sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : counting window; the counter advances only while high
//   clear      : synchronous clear of count and overflow (wins over enable)
//   inc        : increment added each enabled cycle (zero-extended)
//   count      : registered live count
//   overflow   : sticky, set on any carry out of the counter
// MODE selects wrap-around (low bits kept) or saturation at all-ones.
// -----------------------------------------------------------------------------
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned WIDTH     = PERF_DEF_COUNTER_WIDTH,
  parameter int unsigned INC_WIDTH = PERF_DEF_INC_WIDTH,
  parameter perf_mode_e  MODE      = PERF_WRAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count,
  output logic                 overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   sum;

  // The extra top bit of sum is the carry out. A saturated counter stays at
  // all-ones without extra state: any nonzero increment carries again and a
  // zero increment leaves it unchanged.
  always_comb begin
    sum        = {1'b0, count_q} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (enable) begin
      if (sum[WIDTH]) begin
        overflow_d = 1'b1;
        count_d    = (MODE == PERF_SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
        count_d    = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
// NUM_EVENTS event counters plus an elapsed-cycle counter, gated by a counting
// window, with atomic snapshot into shadow registers and an indexed read port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : counting window for event and cycle counters
//   clear         : synchronous clear of live counters and overflow flags
//   snapshot      : copy all live counters into the shadows
//   event_inc     : per-channel increments, channel i at [i*INC_WIDTH +: INC_WIDTH]
//   rd_en, rd_sel : read request; sel NUM_EVENTS reads the cycle shadow
//   rd_data       : registered read result (0 for out-of-range selects)
//   rd_valid      : registered, high the cycle after every rd_en
//   overflow      : sticky overflow per channel, bit NUM_EVENTS = cycle counter
//   snapshot_done : one-cycle pulse once the shadows hold the new snapshot
// -----------------------------------------------------------------------------
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = PERF_DEF_NUM_EVENTS,
  parameter int unsigned COUNTER_WIDTH = PERF_DEF_COUNTER_WIDTH,
  parameter int unsigned INC_WIDTH     = PERF_DEF_INC_WIDTH,
  parameter perf_mode_e  MODE          = PERF_WRAP,
  localparam int unsigned SEL_WIDTH    = perf_sel_width(NUM_EVENTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clear,
  input  logic                            snapshot,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] event_inc,
  input  logic                            rd_en,
  input  logic [SEL_WIDTH-1:0]            rd_sel,
  output logic [COUNTER_WIDTH-1:0]        rd_data,
  output logic                            rd_valid,
  output logic [NUM_EVENTS:0]             overflow,
  output logic                            snapshot_done
);

  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(NUM_EVENTS);

  // Index NUM_EVENTS holds the cycle counter throughout.
  logic [COUNTER_WIDTH-1:0] live     [NUM_EVENTS+1];
  logic [COUNTER_WIDTH-1:0] shadow_q [NUM_EVENTS+1];
  logic [COUNTER_WIDTH-1:0] shadow_d [NUM_EVENTS+1];
  logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     snapshot_done_q, snapshot_done_d;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_event
    perf_counter_cell #(
      .WIDTH     (COUNTER_WIDTH),
      .INC_WIDTH (INC_WIDTH),
      .MODE      (MODE)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .clear    (clear),
      .inc      (event_inc[i*INC_WIDTH +: INC_WIDTH]),
      .count    (live[i]),
      .overflow (overflow[i])
    );
  end

  perf_counter_cell #(
    .WIDTH     (COUNTER_WIDTH),
    .INC_WIDTH (1),
    .MODE      (MODE)
  ) u_cycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .inc      (1'b1),
    .count    (live[NUM_EVENTS]),
    .overflow (overflow[NUM_EVENTS])
  );

  // Shadows take the registered live values, so the increment landing on the
  // same edge is excluded and a simultaneous clear still yields the interval.
  // The read mux looks at shadow_q, so a read alongside a snapshot returns
  // the previous shadow contents.
  always_comb begin
    shadow_d        = shadow_q;
    snapshot_done_d = snapshot;
    rd_valid_d      = rd_en;
    rd_data_d       = '0;
    if (snapshot) begin
      shadow_d = live;
    end
    if (rd_en && (rd_sel <= MAX_SEL)) begin
      rd_data_d = shadow_q[rd_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_EVENTS; i++) begin
        shadow_q[i] <= '0;
      end
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      snapshot_done_q <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      snapshot_done_q <= snapshot_done_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign snapshot_done = snapshot_done_q;

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Multi-channel successor to the single-event performance counter, used in the top-level measurement path. It counts NUM_EVENTS independent event streams plus an elapsed-cycle count, all gated by a software-controlled counting window. Each channel can add a multi-bit increment per cycle, and wraps or saturates per a mode parameter. An atomic snapshot copies every live counter into shadow registers. The shadows are read back through a one-cycle-latency indexed read port.

## Interface
- NUM_EVENTS, 4, number of event channels (1..16)
- COUNTER_WIDTH, 32, width of every live and shadow counter
- INC_WIDTH, 1, width of each per-channel increment (1 = pulse counting)
- MODE, PERF_WRAP, perf_pkg::perf_mode_e; PERF_WRAP wraps modulo 2^COUNTER_WIDTH, PERF_SAT holds at all-ones
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  counting window; counters (event and cycle) advance only while high
- clear  input  1  synchronous clear of live counters and overflow flags
- snapshot  input  1  copy live counters into shadows
- event_inc  input  NUM_EVENTS*INC_WIDTH  per-channel increment, channel i at [i*INC_WIDTH +: INC_WIDTH]
- rd_en  input  1  read request
- rd_sel  input  $clog2(NUM_EVENTS+1)  0..NUM_EVENTS-1 = event shadow i, NUM_EVENTS = cycle shadow
- rd_data  output  COUNTER_WIDTH  read result
- rd_valid  output  1  rd_data qualifier
- overflow  output  NUM_EVENTS+1  sticky per-channel overflow; bit NUM_EVENTS = cycle counter
- snapshot_done  output  1  one-cycle pulse after shadows update

## Operation
- Live event counter i: if clear, set to 0. Else if enable, compute live + zero-extended event_inc[i] in COUNTER_WIDTH+1 bits.
  - Carry-out set: overflow[i] <= 1. In PERF_WRAP the counter takes the low bits; in PERF_SAT it takes all-ones.
  - Once saturated, the counter stays at all-ones until clear.
- Cycle counter: same rules with increment 1 whenever enable, including cycles with no events.
- clear has priority over increment. The overflow flags clear only via clear or reset.
- snapshot captures the registered live values present before the edge; the current cycle's increment is excluded.
- snapshot and clear in the same cycle: shadows get the pre-clear values and live counters go to 0 (interval measurement).
- Shadows are unaffected by clear; they change only on snapshot or reset.
- Read: rd_en with in-range rd_sel returns the selected shadow. Out-of-range rd_sel returns 0.
- rd_valid is asserted for every rd_en, including out-of-range selects.
- Back-to-back reads are allowed, one per cycle.
- A read issued in the same cycle as a snapshot returns the pre-snapshot shadow value.

## Timing
- Reset: all live counters, shadows, overflow, rd_data, rd_valid and snapshot_done are 0.
- Increment is visible on the live counter the cycle after the event_inc/enable edge.
- snapshot at edge N: shadows are valid after edge N, and snapshot_done is high for the cycle following edge N.
- rd_en at edge N: rd_data and rd_valid are registered, valid for the cycle after edge N. rd_valid is low when no rd_en.
- Reset mid-operation returns everything to reset values immediately (asynchronous). There is no partial snapshot.
- There is no handshake back-pressure; all requests are accepted every cycle.

## Structure
- perf_pkg holds:
  - the perf_mode_e typedef (PERF_WRAP, PERF_SAT);
  - default width constants;
  - the function for the rd_sel width.
- Sub-module perf_counter_cell (one live counter plus sticky overflow, parameterised by width, increment width and mode) is instantiated NUM_EVENTS+1 times. The cycle counter instance has increment tied to 1.
- Shadow registers and the read mux live in perf_monitor.

## Test plan
- Reset, enable=1, channel 0 pulsed 5 times, 10 cycles elapsed, then snapshot -> reads: sel 0 = 5, sel NUM_EVENTS = 10, others 0, overflow = 0.
- INC_WIDTH=4, channel 1 driven 7 for 3 cycles while enable toggles 1,0,1 -> shadow 1 = 14, cycle shadow = 2.
- COUNTER_WIDTH=8, PERF_WRAP: 300 pulses on channel 0 -> value 44, overflow[0]=1. Repeat with PERF_SAT -> value 255, overflow[0]=1. clear -> value 0, overflow 0.
- snapshot and clear in the same cycle with live channel 2 = 9 -> shadow 2 = 9, live 0. The next snapshot after 3 pulses -> shadow 2 = 3.
- rd_en with rd_sel = NUM_EVENTS+1 -> rd_valid=1, rd_data=0. Read concurrent with snapshot -> old shadow value, then the new value on the next read.
- Assert rst_n low mid-count with nonzero shadows -> all outputs 0 immediately. After release, counting restarts from 0.
